// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory, redirect and decode-side signals of the fetch stage
interface fetch_unit_if #(parameter int CNT_W = 3);
    logic              pc_enable;
    logic              redirect_valid;
    logic [31:0]       redirect_addr;
    logic [31:0]       inst_addr;
    logic [31:0]       instr;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_ready;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        input  pc_enable, redirect_valid, redirect_addr, instr, out_ready,
        output inst_addr, out_valid, out_instr, out_pc, fifo_count
    );

    modport slave (
        output pc_enable, redirect_valid, redirect_addr, instr, out_ready,
        input  inst_addr, out_valid, out_instr, out_pc, fifo_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from Memory and buffers {pc, instr} pairs for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 3
) (
    input logic          clk,
    input logic          pc_reset_n,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {FETCH, STALL, IDLE, FLUSH} mode_t;

    mode_t            mode;
    logic [31:0]      pc;
    logic [31:0]      pcs [DEPTH];
    logic [31:0]      instrs [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full, pop, push;

    assign bus.inst_addr  = pc;
    assign bus.out_valid  = count != '0;
    assign bus.out_instr  = instrs[rd_ptr];
    assign bus.out_pc     = pcs[rd_ptr];
    assign bus.fifo_count = count;

    // Mode is decided fresh every cycle; only FETCH pushes and advances the PC
    always_comb begin
        pop  = bus.out_valid && bus.out_ready;
        full = count == CNT_W'(DEPTH);
        mode = bus.redirect_valid ? FLUSH :
               !bus.pc_enable     ? IDLE  :
               (full && !pop)     ? STALL : FETCH;
        push = mode == FETCH;
    end

    always_ff @(posedge clk) begin
        if (!pc_reset_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcs[i]    <= '0;
                instrs[i] <= '0;
            end
        end else if (mode == FLUSH) begin
            pc     <= {bus.redirect_addr[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pcs[wr_ptr]    <= pc;
                instrs[wr_ptr] <= bus.instr;
                wr_ptr         <= wr_ptr + 1'b1;
                pc             <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random traffic checked against a queue-based model
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam int          CNT_W = 3;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] mpc;
    logic [63:0] q[$];
    bit          model_ok = 0;

    fetch_unit_if #(.CNT_W(CNT_W)) bus ();

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .pc_reset_n (rst_n),
        .bus        (bus.master)
    );

    assign bus.instr = bus.inst_addr ^ KEY;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare against the model, cross one rising edge, advance the model, park on the falling edge
    task automatic tick();
        bit pop, push;
        if (model_ok) begin
            check("inst_addr", bus.inst_addr, mpc);
            check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_pc", bus.out_pc, q[0][63:32]);
                check("out_instr", bus.out_instr, q[0][31:0]);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            mpc = 32'h0;
            q.delete();
            model_ok = 1;
        end else if (bus.redirect_valid) begin
            mpc = {bus.redirect_addr[31:2], 2'b00};
            q.delete();
        end else begin
            pop  = q.size() != 0 && bus.out_ready;
            push = bus.pc_enable && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({mpc, mpc ^ KEY});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.pc_enable      = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        @(negedge clk);
        repeat (5) tick();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_addr", bus.inst_addr, 0);
        rst_n = 1'b1;
        tick();
        check("rel_addr1", bus.inst_addr, 32'h4);
        check("rel_first_pc", bus.out_pc, 32'h0);
        check("rel_first_valid", 32'(bus.out_valid), 1);
        repeat (4) tick();

        // Backpressure from a fresh start
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        repeat (6) tick();
        check("bp_count", 32'(bus.fifo_count), 2);
        check("bp_addr", bus.inst_addr, 32'h8);
        check("bp_out_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_pop_count", 32'(bus.fifo_count), 2);
        check("bp_pop_addr", bus.inst_addr, 32'hC);
        check("bp_pop_out_pc", bus.out_pc, 32'h4);

        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        check("rd_valid", 32'(bus.out_valid), 0);
        check("rd_count", 32'(bus.fifo_count), 0);
        check("rd_addr", bus.inst_addr, 32'h100);
        bus.out_ready = 1'b1;
        tick();
        check("rd_out_pc", bus.out_pc, 32'h100);
        check("rd_out_valid", 32'(bus.out_valid), 1);

        bus.pc_enable = 1'b0;
        repeat (10) tick();
        check("en_count", 32'(bus.fifo_count), 0);
        check("en_addr", bus.inst_addr, 32'h104);
        bus.pc_enable = 1'b1;
        tick();
        check("en_resume_pc", bus.out_pc, 32'h104);

        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        check("wrap_addr", bus.inst_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", bus.out_pc, 32'h0000_0000);

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0500;
        tick();
        check("rr_addr", bus.inst_addr, 32'h0);
        check("rr_count", 32'(bus.fifo_count), 0);
        check("rr_valid", 32'(bus.out_valid), 0);
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;

        for (int i = 0; i < 400; i++) begin
            bus.pc_enable      = $urandom_range(0, 7) != 0;
            bus.out_ready      = $urandom_range(0, 2) != 0;
            bus.redirect_valid = $urandom_range(0, 19) == 0;
            bus.redirect_addr  = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rst_n              = $urandom_range(0, 99) != 0;
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the processor core's decode path.
- Owns the program counter and drives inst_addr to the Memory instruction port.
- Captures the returned instr word into a small FIFO and presents {pc, instr} pairs to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from the core, which flush the buffer and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch FIFO entries; legal values are 2 or 4 (power of two).
- CNT_W, 3, width of fifo_count; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- pc_reset_n  in  1  synchronous active-low reset.
- pc_enable  in  1  fetch enable; when low, no new fetch is pushed and the PC holds.
- redirect_valid  in  1  core requests a PC change this cycle.
- redirect_addr  in  32  target address; bits [1:0] are ignored.
- inst_addr  out  32  address to Memory; combinational copy of the PC register.
- instr  in  32  instruction word from Memory, combinationally valid for the current inst_addr.
- out_valid  out  1  FIFO head holds a valid entry.
- out_instr  out  32  instruction at the FIFO head.
- out_pc  out  32  PC of out_instr.
- out_ready  in  1  decode accepts the head entry this cycle.
- fifo_count  out  CNT_W  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (pc_reset_n low at a rising edge): pc <= RESET_PC; FIFO emptied; rd_ptr = wr_ptr = 0.
  - After reset: out_valid = 0, fifo_count = 0, out_instr and out_pc = 0.
  - Reset overrides redirect, push and pop in the same cycle.
  - Reset mid-stream drops all buffered entries.
- Definitions: pop = out_valid && out_ready; full = (fifo_count == DEPTH).
- push = pc_enable && !redirect_valid && (!full || pop). Pushing when full is allowed only if a pop occurs in the same cycle.
- On push: the entry {inst_addr, instr} is written at wr_ptr; pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- On pop: rd_ptr advances.
- fifo_count update: push and pop together leave it unchanged; push only increments it; pop only decrements it.
- Fetch latency: an instr sampled at edge N appears at out_* after edge N (out_valid high in cycle N+1) when the FIFO was empty. Sustained throughput is 1 instr per cycle with out_ready held high.
- Stall: if pc_enable is low, or the FIFO is full with no pop, the PC holds and inst_addr is stable.
- Redirect (redirect_valid high, not in reset):
  - FIFO flushed: fifo_count <= 0 and out_valid low the next cycle; any pop that cycle is still counted as consumed by decode.
  - pc <= {redirect_addr[31:2], 2'b00}.
  - No push that cycle.
  - First fetch from the target occurs the following cycle, if pc_enable is high.
- Redirect with pc_enable low: PC still loads; fetching resumes at the target when pc_enable rises.
- out_instr and out_pc are driven from the FIFO head register array, not through a combinational path from instr.
- Internal state: FETCH (pc_enable high, pushing), STALL (pc_enable high, full with no pop), IDLE (pc_enable low), FLUSH (redirect cycle, one cycle only, then FETCH or IDLE).
  - State is reported nowhere.
  - It exists to structure the RTL; the implementation may encode it implicitly.

Test Plan:
- Reset release:
  - Stimulus: pc_reset_n low 5 cycles, then high; pc_enable=1, out_ready=1; Memory returns instr = address ^ 32'hA5A5_A5A5.
  - Required: inst_addr = 0,4,8,... each cycle; out_pc = 0 with out_valid high in the 2nd cycle after release; one entry per cycle thereafter.
- Backpressure:
  - Stimulus: out_ready=0 with DEPTH=2.
  - Required: fifo_count reaches 2; inst_addr holds at 8; out_pc stays 0.
  - Then raise out_ready for 1 cycle: entry 0 popped, pc 8 pushed in the same edge, fifo_count remains 2, inst_addr becomes 12.
- Redirect:
  - Stimulus: with 2 entries buffered, redirect_valid=1, redirect_addr=32'h0000_0103.
  - Required: next cycle out_valid=0, fifo_count=0, inst_addr=32'h0000_0100; following cycle out_pc=32'h100.
- Enable gating:
  - Stimulus: pc_enable=0 for 10 cycles.
  - Required: no pushes; FIFO drains to 0; inst_addr constant; resuming pc_enable=1 continues from the held PC.
- Wrap and reset mid-operation:
  - Stimulus: redirect to 32'hFFFF_FFF8.
  - Required: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Stimulus: assert pc_reset_n low mid-stream, coincident with redirect_valid.
  - Required: PC = RESET_PC, fifo_count = 0, redirect ignored.
